// File: rtl/fix_add_pipe.sv
// Two-stage pipelined signed fixed-point adder/accumulator with a valid/ready handshake and per-lane accumulators.
// Define FIX_ADD_PIPE_SAT_EN for saturating results; otherwise results wrap and overflow is only reported.
module fix_add_pipe #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_sum,
    output logic [LANES-1:0]         out_ovf,
    output logic [LANES-1:0]         ovf_sticky,
    input  logic                     ovf_clr
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Exact result needs one guard bit; it overflowed when the top two bits differ.
    function automatic logic is_ovf(input logic [WIDTH:0] x);
        return x[WIDTH] ^ x[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] x);
`ifdef FIX_ADD_PIPE_SAT_EN
        if (is_ovf(x))
            return x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            return x[WIDTH-1:0];
`else
        return x[WIDTH-1:0];
`endif
    endfunction

    function automatic logic [WIDTH:0] lane_calc(input op_e op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] acc);
        logic [WIDTH:0] a_x;
        logic [WIDTH:0] b_x;
        logic [WIDTH:0] acc_x;
        a_x   = {a[WIDTH-1], a};
        b_x   = {b[WIDTH-1], b};
        acc_x = {acc[WIDTH-1], acc};
        case (op)
            OP_ADD:  return a_x + b_x;
            OP_SUB:  return a_x - b_x;
            OP_ACC:  return acc_x + a_x;
            default: return a_x;
        endcase
    endfunction

    op_e              w_op;
    logic             w_stall;
    logic             w_accept;
    logic             w_acc_upd;
    logic [WIDTH:0]   w_s1_res [LANES];
    logic [LANES-1:0] w_s2_ovf;

    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_res [LANES];
    logic [WIDTH-1:0] r_acc    [LANES];

    assign w_op      = op_e'(in_op);
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign w_accept  = in_valid && in_ready;
    assign w_acc_upd = (w_op == OP_ACC) || (w_op == OP_LOAD);

    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_s1_res[i] = lane_calc(w_op, in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH], r_acc[i]);
    end

    always_comb begin
        w_s2_ovf = '0;
        for (int i = 0; i < LANES; i++)
            w_s2_ovf[i] = is_ovf(r_s1_res[i]);
    end

    // NOTE: the per-lane accumulators and stage registers are real architectural state, so they are reset
    // explicitly rather than treated as don't-care storage; non-blocking assignments keep every read
    // in this block seeing the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_res   <= '{default: '0};
            r_acc      <= '{default: '0};
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_ovf    <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_s1_res[i] <= w_s1_res[i];
                    if (w_acc_upd)
                        r_acc[i] <= fit(w_s1_res[i]);
                end
            end
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                for (int i = 0; i < LANES; i++)
                    out_sum[i*WIDTH +: WIDTH] <= fit(r_s1_res[i]);
                out_ovf <= w_s2_ovf;
            end
        end
    end

    // Clear takes priority over an overflow landing in stage 2 on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_sticky <= '0;
        else if (ovf_clr)
            ovf_sticky <= '0;
        else if (!w_stall && r_s1_valid)
            ovf_sticky <= ovf_sticky | w_s2_ovf;
    end

endmodule

// File: tb/tb_fix_add_pipe.sv
// Directed self-checking bench for fix_add_pipe (WIDTH=32, LANES=2); honours FIX_ADD_PIPE_SAT_EN for expectations.
module tb_fix_add_pipe;
    localparam int W = 32;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [L*W-1:0] in_a;
    logic [L*W-1:0] in_b;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] out_sum;
    logic [L-1:0]   out_ovf;
    logic [L-1:0]   ovf_sticky;
    logic           ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  s_op  [8];
    logic [31:0] s_a   [8];
    logic [31:0] s_b   [8];
    logic [31:0] s_exp [8];
    logic [1:0]  s_ovf [8];
    int          s_n;

`ifdef FIX_ADD_PIPE_SAT_EN
    localparam logic [31:0] ADD_OVF_EXP = 32'h7FFF_FFFF;
    localparam logic [31:0] SUB_OVF_EXP = 32'h8000_0000;
`else
    localparam logic [31:0] ADD_OVF_EXP = 32'h8000_0000;
    localparam logic [31:0] SUB_OVF_EXP = 32'h7FFF_FFFF;
`endif

    fix_add_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input logic [1:0] op, input logic [31:0] a0, input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] b1);
        in_op = op;
        in_a  = {a1, a0};
        in_b  = {b1, b0};
    endtask

    // Send one beat with out_ready high and confirm the two-edge latency.
    task automatic one_beat(input string tag, input logic [1:0] op, input logic [31:0] a0,
                            input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1);
        set_beat(op, a0, b0, a1, b1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid_edge1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid_edge2"}, 64'(out_valid), 64'd1);
    endtask

    // Streams s_op/s_a/s_b beats (lane 1 zero), optionally stalling the consumer, and checks lane-0 results in order.
    task automatic run_stream(input string tag, input int stall_start, input int stall_len);
        int  idx  = 0;
        int  ridx = 0;
        int  cyc  = 0;
        logic take;
        while (ridx < s_n && cyc < 40) begin
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            in_valid  = (idx < s_n);
            if (idx < s_n)
                set_beat(s_op[idx], s_a[idx], s_b[idx], 32'd0, 32'd0);
            #1;
            if (out_valid && !out_ready)
                check($sformatf("%s_stall_in_ready_c%0d", tag, cyc), 64'(in_ready), 64'd0);
            take = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("%s_sum%0d", tag, ridx), 64'(out_sum), {32'd0, s_exp[ridx]});
                check($sformatf("%s_ovf%0d", tag, ridx), 64'(out_ovf), 64'(s_ovf[ridx]));
                ridx++;
            end
            @(posedge clk); #1;
            if (take)
                idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_all_retired"}, 64'(ridx), 64'(s_n));
        check({tag, "_no_extra"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        set_beat(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_sticky", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Add overflow on lane 0 alongside an ordinary lane-1 add
        one_beat("add", 2'b00, 32'h7FFF_FFFF, 32'd1, 32'd3, 32'd4);
        check("add_sum", 64'(out_sum), {32'd7, ADD_OVF_EXP});
        check("add_ovf", 64'(out_ovf), 64'h1);
        check("add_sticky", 64'(ovf_sticky), 64'h1);
        @(posedge clk); #1;
        check("add_valid_drop", 64'(out_valid), 64'd0);
        check("add_sticky_hold", 64'(ovf_sticky), 64'h1);

        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("clr_sticky", 64'(ovf_sticky), 64'd0);

        // Subtract underflow
        one_beat("sub", 2'b01, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
        check("sub_sum", 64'(out_sum), {32'd0, SUB_OVF_EXP});
        check("sub_ovf", 64'(out_ovf), 64'h1);
        check("sub_sticky", 64'(ovf_sticky), 64'h1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("sub_clr_sticky", 64'(ovf_sticky), 64'd0);

        // Clear arriving on the same edge as a new overflow wins
        set_beat(2'b00, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ovf_clr  = 1'b1;
        @(posedge clk); #1;
        ovf_clr  = 1'b0;
        check("clrwin_ovf", 64'(out_ovf), 64'h1);
        check("clrwin_sticky", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;

        // Load then back-to-back accumulates
        s_n = 4;
        s_op[0] = 2'b11; s_a[0] = 32'd10;  s_b[0] = 32'd0; s_exp[0] = 32'd10;  s_ovf[0] = 2'b00;
        s_op[1] = 2'b10; s_a[1] = 32'd5;   s_b[1] = 32'd9; s_exp[1] = 32'd15;  s_ovf[1] = 2'b00;
        s_op[2] = 2'b10; s_a[2] = 32'd5;   s_b[2] = 32'd9; s_exp[2] = 32'd20;  s_ovf[2] = 2'b00;
        s_op[3] = 2'b10; s_a[3] = -32'sd30; s_b[3] = 32'd9; s_exp[3] = -32'sd10; s_ovf[3] = 2'b00;
        run_stream("acc", 100, 0);

        // Backpressure mid-stream
        for (int i = 0; i < 4; i++) begin
            s_op[i]  = 2'b00;
            s_a[i]   = 32'(i + 1);
            s_b[i]   = 32'(i + 1);
            s_exp[i] = 32'(2 * (i + 1));
            s_ovf[i] = 2'b00;
        end
        run_stream("bp", 2, 3);

        // Reset with two beats in flight and acc = 100
        s_n = 1;
        s_op[0] = 2'b11; s_a[0] = 32'd100; s_b[0] = 32'd0; s_exp[0] = 32'd100; s_ovf[0] = 2'b00;
        run_stream("load100", 100, 0);
        out_ready = 1'b0;
        set_beat(2'b10, 32'd1, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(out_sum), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        s_op[0] = 2'b10; s_a[0] = 32'd1; s_b[0] = 32'd0; s_exp[0] = 32'd1; s_ovf[0] = 2'b00;
        run_stream("postrst", 100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fix_add_pipe.md
# fix_add_pipe

Parametrised, pipelined signed fixed-point adder/accumulator with a valid/ready handshake on input and output, and a per-lane running accumulator. It generalises the single-cycle 32-bit combinational adder to configurable width and lane count, registered two-stage latency, add/subtract/accumulate/load modes and overflow detection. It sits between operand producers (state-update datapath) and downstream fixed-point consumers that can apply backpressure.

## Interface
- WIDTH, 32, operand/result width per lane, two's complement, ≥ 4
- LANES, 1, number of parallel lanes sharing one handshake, ≥ 1
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- in_op  input  2  00 add a+b; 01 sub a−b; 10 accumulate acc+a; 11 load acc=a
- in_a  input  LANES*WIDTH  packed signed operands, lane i at [i*WIDTH +: WIDTH]
- in_b  input  LANES*WIDTH  packed signed operands (ignored for ops 10/11)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- out_sum  output  LANES*WIDTH  packed signed results
- out_ovf  output  LANES  per-lane overflow of this beat
- ovf_sticky  output  LANES  per-lane OR of all out_ovf since reset/clear
- ovf_clr  input  1  clears ovf_sticky (synchronous)

## Operation
- Accept when in_valid && in_ready. Stall = out_valid && !out_ready; in_ready = !stall. When stalled, both stages hold.
- Stage 1 (on accept): compute WIDTH+1-bit exact result per lane; register it with op. Ops 10/11 update acc[i] in the same edge: acc ← fit(acc + a) / acc ← a; result = new acc value. Op 11 never overflows.
- Stage 2: fit() WIDTH+1 result to WIDTH, set out_ovf[i] when the exact result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]; register as out_sum/out_ovf, assert out_valid.
- fit(): saturate or wrap per Configuration; same function used for acc update, so acc and out_sum always agree.
- ovf_sticky[i] ← (ovf_sticky[i] | out_ovf[i] captured into stage 2) unless ovf_clr; ovf_clr wins over a simultaneous new overflow in the same cycle.
- Beat not accepted (in_valid=0 or stall): acc unchanged, no bubble advances into a held stage.
- Output beat retires when out_valid && out_ready; if no new data behind it, out_valid drops next cycle.

## Timing
- Reset (async assert, sync deassert at clk): out_valid=0, out_sum=0, out_ovf=0, ovf_sticky=0, acc=0, stage-1 valid=0; in_ready=1 during and after reset.
- Latency: beat accepted at edge N appears on out_sum/out_valid after edge N+1 (2 registered stages).
- Throughput: one beat per cycle while out_ready=1.
- Back-to-back accumulate ops use the acc value updated at the previous accept edge, no hazard bubble.
- Reset mid-operation: in-flight beats discarded, acc cleared; no partial beat emitted.
- out_sum/out_ovf stable while out_valid && !out_ready.

## Configuration
- FIX_ADD_PIPE_SAT_EN defined: fit() saturates to 2^(WIDTH−1)−1 or −2^(WIDTH−1); acc saturates identically.
- Undefined: fit() wraps (truncates to WIDTH LSBs); out_ovf/ovf_sticky still report overflow.

## Test plan
- Add, WIDTH=32: a=0x7FFFFFFF, b=1 -> with SAT_EN out_sum=0x7FFFFFFF, out_ovf=1; without -> 0x80000000, out_ovf=1; out_valid two edges after accept.
- Sub: a=0x80000000, b=1 -> SAT_EN 0x80000000, ovf=1, ovf_sticky=1; then ovf_clr=1 -> ovf_sticky=0 next cycle.
- Accumulate: load 10, then acc 5, 5, −30 back-to-back -> out_sum sequence 10, 15, 20, −10, ovf all 0.
- Backpressure: stream 4 adds (1+1, 2+2, 3+3, 4+4), out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, outputs 2,4,6,8 in order, none lost or duplicated.
- LANES=2: lane0 0x7FFFFFFF+1, lane1 3+4 in one beat -> out_ovf=2'b01, lane1 out_sum=7.
- Reset mid-stream: assert rst with two beats in flight and acc=100 -> out_valid=0 immediately, acc=0; next acc op with a=1 returns 1.
